uart_tx_ser: RTL and testbench



---
 rtl/uart_tx_ser.sv | 136 +++++++++++++
 tb/tb_uart_tx_ser.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ser.sv
// UART transmit serializer.
// Accepts a parallel word over valid/ready and shifts it out LSB-first on txd:
// start bit, WORD_WIDTH data bits, optional parity bit, then one or two stop
// bits. Every bit lasts OVERSAMPLING pulses of the shared baud tick.
module uart_tx_ser #(
    parameter int WORD_WIDTH   = 8,
    parameter int OVERSAMPLING = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  stop2,
    output logic                  txd,
    output logic                  done,
    output logic                  active
);

    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(WORD_WIDTH + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [TW-1:0]         tick_ctr;
    logic [BW-1:0]         bit_ctr;
    logic                  stop_ctr;
    logic [WORD_WIDTH-1:0] shift;
    logic [WORD_WIDTH-1:0] shift_next;
    logic                  parity_bit;
    logic                  parity_en_q;
    logic                  stop2_q;

    // Next data bit is the LSB of the shifted word; written this way so a
    // one-bit word does not index past the top of the register.
    assign shift_next = shift >> 1;

    // Handshake and activity flags follow the registered state directly.
    assign ready  = (state == IDLE);
    assign active = (state != IDLE);

    // Frame sequencer: latches the word on acceptance, then advances one bit
    // every OVERSAMPLING ticks; txd and done are driven straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: async reset forces the line idle at once; every state flop
            // is updated with <= so all of them see pre-edge values.
            state       <= IDLE;
            txd         <= 1'b1;
            done        <= 1'b0;
            tick_ctr    <= '0;
            bit_ctr     <= '0;
            stop_ctr    <= 1'b0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            parity_en_q <= 1'b0;
            stop2_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                txd <= 1'b1;
                // Ticks are ignored here, including one in the acceptance cycle.
                if (valid) begin
                    shift       <= din;
                    parity_bit  <= (^din) ^ parity_odd;
                    parity_en_q <= parity_en;
                    stop2_q     <= stop2;
                    tick_ctr    <= TICK_LAST;
                    txd         <= 1'b0;
                    state       <= START;
                end
            end else if (tick) begin
                if (tick_ctr != '0) begin
                    tick_ctr <= tick_ctr - 1'b1;
                end else begin
                    // End of the current bit period.
                    tick_ctr <= TICK_LAST;
                    case (state)
                        START: begin
                            state   <= DATA;
                            txd     <= shift[0];
                            bit_ctr <= '0;
                        end
                        DATA: begin
                            shift   <= shift_next;
                            bit_ctr <= bit_ctr + 1'b1;
                            if (bit_ctr == BIT_LAST) begin
                                if (parity_en_q) begin
                                    state <= PARITY;
                                    txd   <= parity_bit;
                                end else begin
                                    state    <= STOP;
                                    txd      <= 1'b1;
                                    stop_ctr <= 1'b0;
                                end
                            end else begin
                                txd <= shift_next[0];
                            end
                        end
                        PARITY: begin
                            state    <= STOP;
                            txd      <= 1'b1;
                            stop_ctr <= 1'b0;
                        end
                        STOP: begin
                            if (stop2_q && !stop_ctr) begin
                                stop_ctr <= 1'b1;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            txd   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser (WORD_WIDTH=8, OVERSAMPLING=16).
// Each frame is walked bit by bit; every bit window must hold the expected
// level for exactly 16*div clock cycles, with ticks every div clocks.
module tb_uart_tx_ser;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] din;
    logic       valid;
    logic       ready;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
    logic       txd;
    logic       done;
    logic       active;

    int checks = 0;
    int errors = 0;
    int div    = 1;
    int tcnt   = 0;
    bit tick_en = 1'b1;

    uart_tx_ser #(
        .WORD_WIDTH  (8),
        .OVERSAMPLING(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .din       (din),
        .valid     (valid),
        .ready     (ready),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .stop2     (stop2),
        .txd       (txd),
        .done      (done),
        .active    (active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    // The tick for the next edge is driven here: high when tcnt hits div-1.
    task automatic step();
        @(posedge clk);
        #1;
        tcnt = (tcnt + 1) % div;
        tick = tick_en && (tcnt == div - 1);
    endtask

    // Present a word for one edge. The tick phase is set so the acceptance
    // cycle carries a tick (which must be ignored) and the next tick arrives
    // div edges later, making every bit exactly 16*div cycles long.
    task automatic accept(input logic [7:0] w, input logic pe, input logic po,
                          input logic s2, input int d);
        check("ready_before_accept", ready, 1);
        din        = w;
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        div        = d;
        tcnt       = d - 1;
        tick       = tick_en;
        valid      = 1'b1;
        step();
        valid = 1'b0;
    endtask

    // Walk one frame from the cycle after acceptance up to the final edge.
    task automatic walk(input logic [7:0] w, input logic pe, input logic po,
                        input logic s2, input bit perturb, input bit stall);
        logic exp_bits [0:11];
        int   n;
        int   len;
        int   hit;
        int   hit_s;
        int   dn;
        int   busy;
        int   total;
        n = 0;
        exp_bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            exp_bits[n] = w[i]; n++;
        end
        if (pe) begin
            exp_bits[n] = (^w) ^ po; n++;
        end
        exp_bits[n] = 1'b1; n++;
        if (s2) begin
            exp_bits[n] = 1'b1; n++;
        end
        len   = 16 * div;
        dn    = 0;
        busy  = 0;
        total = 0;
        for (int b = 0; b < n; b++) begin
            hit = 0;
            for (int k = 0; k < len; k++) begin
                if (perturb && b == 3 && k == 0) begin
                    din        = ~w;
                    stop2      = ~s2;
                    parity_en  = ~pe;
                    parity_odd = ~po;
                end
                if (stall && b == 4 && k == len / 2) begin
                    tick_en = 1'b0;
                    tick    = 1'b0;
                    hit_s   = 0;
                    repeat (100) begin
                        if (txd === exp_bits[b]) hit_s++;
                        if (done !== 1'b0) dn++;
                        step();
                    end
                    check("stall_hold", hit_s, 100);
                    tick_en = 1'b1;
                    tick    = (tcnt == div - 1);
                end
                if (txd === exp_bits[b]) hit++;
                if (done !== 1'b0) dn++;
                if (ready === 1'b0 && active === 1'b1) busy++;
                total++;
                step();
            end
            check($sformatf("bit%0d_len", b), hit, len);
        end
        check("no_early_done", dn, 0);
        check("busy_in_frame", busy, total);
        check("done_pulse", done, 1);
        check("ready_after_done", ready, 1);
    endtask

    initial begin
        int cnt_txd;
        int cnt_done;

        rst_n      = 1'b0;
        tick       = 1'b0;
        din        = 8'h00;
        valid      = 1'b0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 1);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_active", active, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // 0x55, no parity, one stop bit, tick every clk.
        accept(8'h55, 1'b0, 1'b0, 1'b0, 1);
        walk(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("done_one_cycle_55", done, 0);

        // 0x07 even parity (parity bit 1), then odd parity (parity bit 0).
        accept(8'h07, 1'b1, 1'b0, 1'b0, 1);
        walk(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("done_one_cycle_07e", done, 0);
        accept(8'h07, 1'b1, 1'b1, 1'b0, 1);
        walk(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("done_one_cycle_07o", done, 0);

        // 0xA3, two stop bits, tick every 4 clk, inputs disturbed mid-frame.
        accept(8'hA3, 1'b0, 1'b0, 1'b1, 4);
        walk(8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check("done_one_cycle_a3", done, 0);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        div        = 1;
        tcnt       = 0;
        tick       = tick_en;
        repeat (2) step();

        // Back-to-back 0x01 then 0xFF with valid held high.
        accept(8'h01, 1'b0, 1'b0, 1'b0, 1);
        din   = 8'hFF;
        valid = 1'b1;
        walk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        valid = 1'b0;
        check("b2b_done_one_cycle", done, 0);
        check("b2b_start_immediate", txd, 0);
        check("b2b_ready_low", ready, 0);
        walk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Reset in the middle of data bit 3 (0xC6: bit3 = 0).
        accept(8'hC6, 1'b0, 1'b0, 1'b0, 1);
        repeat (16 + 3 * 16 + 5) step();
        check("pre_rst_txd", txd, 0);
        check("pre_rst_active", active, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_active", active, 0);
        cnt_done = 0;
        repeat (3) begin
            step();
            if (done !== 1'b0) cnt_done++;
        end
        rst_n = 1'b1;
        cnt_txd = 0;
        repeat (20) begin
            if (txd === 1'b1) cnt_txd++;
            if (done !== 1'b0) cnt_done++;
            step();
        end
        check("post_rst_no_done", cnt_done, 0);
        check("post_rst_idle", cnt_txd, 20);
        accept(8'h3C, 1'b0, 1'b0, 1'b0, 1);
        walk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Ticks stopped for 100 cycles in the middle of data bit 3.
        accept(8'h96, 1'b0, 1'b0, 1'b0, 1);
        walk(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("done_one_cycle_96", done, 0);

        // Valid low with ticks running: line stays idle, no done.
        cnt_txd  = 0;
        cnt_done = 0;
        repeat (50) begin
            if (txd === 1'b1) cnt_txd++;
            if (done !== 1'b0) cnt_done++;
            step();
        end
        check("idle_txd_high", cnt_txd, 50);
        check("idle_no_done", cnt_done, 0);
        check("idle_ready", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
